bus_slave_8085: RTL and testbench
=================================

Name: bus_slave_8085

Overview:
- Downstream consumer of the CPU's multiplexed external bus.
- Latches the low address on ALE, classifies the machine cycle from IOMn/S1/S0, and services it:
  - an internal byte RAM for memory cycles,
  - one output port and one input port for I/O cycles.
- Drives read data back onto the AD bus and inserts programmable wait states through READY.
- Sits on the board side of the CPU pins; clocked by the CPU clock output.

Parameters:
- MEM_AW, 10, RAM address width; RAM holds 2^MEM_AW bytes; higher address bits alias.
- WAIT_STATES, 1, wait cycles inserted per access (0..7).
- IO_OUT_PORT, 8'h10, I/O address of the output latch.
- IO_IN_PORT, 8'h11, I/O address of the input port.

Ports:
- clk  input  1  clock (CPU clock output)
- resetn_in  input  1  reset, synchronous, active-low
- haddress  input  8  high address byte
- ad_in  input  8  sampled value of the multiplexed address/data bus
- ad_out  output  8  data driven onto the AD bus
- ad_oe  output  1  AD bus drive enable
- ale  input  1  address latch enable
- s0, s1, iomn  input  1 each  status / IO-memory select
- rdn, wrn  input  1 each  active-low read/write strobes
- ready  output  1  0 = CPU must wait
- io_in  input  8  external input port value
- io_out  output  8  output port latch
- cycle_type  output  3  class of the current cycle
- bus_err  output  1  sticky protocol error flag

Behaviour:
- Reset values (resetn_in low at a clk edge):
  - state IDLE; ad_out 8'h00; ad_oe 0; ready 1; io_out 8'h00; cycle_type 3'b000; bus_err 0.
  - RAM contents are not reset.
- ALE latching:
  - Any edge with ale=1, in any state, latches addr={haddress,ad_in} and status={iomn,s1,s0}.
  - The block then enters ADDR.
  - If ale=1 arrives in a non-IDLE state, the current access aborts: ad_oe is 0 the next cycle and no write commits.
- cycle_type decode from {iomn,s1,s0}, registered in the ALE cycle:
  - 011 -> 001 opcode fetch
  - 010 -> 010 mem read
  - 001 -> 011 mem write
  - 110 -> 100 IO read
  - 101 -> 101 IO write
  - 111 -> 110 INTA
  - 000 (halt) and 100 -> 000 idle; the block stays in IDLE.
- FSM states: IDLE, ADDR, WAIT, READ, WRITE, ERR.
- ADDR:
  - rdn=0 and wrn=1 -> WAIT, with ready=0 next cycle and wait counter loaded with WAIT_STATES. If WAIT_STATES=0, go directly to READ.
  - wrn=0 and rdn=1 -> WAIT, then WRITE.
  - rdn=0 and wrn=0 -> ERR.
- WAIT:
  - ready=0; the counter decrements each cycle.
  - When the counter reaches 1, the next state is READ or WRITE and ready=1.
  - Total ready-low time is exactly WAIT_STATES cycles.
- READ:
  - ad_oe=1 and ad_out holds the read data for every cycle while rdn=0.
  - First cycle with rdn sampled 1 -> IDLE; ad_oe is 0 on the following cycle.
  - Read data by cycle type:
    - memory cycles: RAM[addr[MEM_AW-1:0]]
    - IO read at addr[7:0]==IO_IN_PORT: io_in sampled on READ entry
    - any other IO read: 8'hFF
    - INTA: 8'hFF
- WRITE:
  - ad_in is captured every cycle wrn=0.
  - On the first cycle wrn is sampled 1 (rising edge), the last captured byte commits:
    - mem write -> RAM[addr[MEM_AW-1:0]]
    - IO write at IO_OUT_PORT -> io_out
    - other IO ports are ignored.
  - Then IDLE.
  - A write strobe seen during a read-class cycle, or vice versa, still executes per the strobe; cycle_type is informational only.
- ERR:
  - bus_err set; no drive, no commit.
  - Returns to IDLE when rdn=wrn=1.
  - bus_err clears only on reset.
- Read-during-write hazard: none. A RAM write commits before any later read, since they are in different bus cycles.
- Address wrap: addr 16'hFFFF maps to RAM[2^MEM_AW-1]; there is no out-of-range error.

Optional Feature:
- Macro: BUS_SLAVE_STATS_EN.
- When defined:
  - Adds output ports fetch_cnt[15:0] and wait_cnt[15:0], both reset to 0.
  - fetch_cnt increments once per completed opcode-fetch READ.
  - wait_cnt increments every cycle ready=0.
  - Both counters wrap from 16'hFFFF to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with WAIT_STATES=1: hold resetn_in=0 two cycles -> ad_oe=0, ready=1, io_out=00, cycle_type=000, bus_err=0.
- Mem write then read, WAIT_STATES=1:
  - ALE addr 16'h0123 with {iomn,s1,s0}=001, wrn low 2 cycles with ad_in=8'h5A -> ready low exactly 1 cycle.
  - ALE 16'h0123 with 010, rdn low -> ad_oe=1, ad_out=8'h5A.
  - ad_oe drops 1 cycle after rdn rises.
- Aliasing, MEM_AW=10: write 8'hC3 to 16'h0400, read 16'h0000 with 011 -> ad_out=8'hC3, cycle_type=001.
- IO:
  - OUT to 8'h10 with data 8'hA5 -> io_out=8'hA5.
  - IN from 8'h11 with io_in=8'h3C -> ad_out=8'h3C.
  - IN from 8'h12 -> 8'hFF.
- Faults:
  - rdn=wrn=0 after ALE -> bus_err=1, ad_oe stays 0, RAM unchanged.
  - ALE pulse mid-READ -> ad_oe=0 next cycle and the new address is latched.
- WAIT_STATES=0 with BUS_SLAVE_STATS_EN: three opcode fetches -> ready never low, fetch_cnt=3, wait_cnt=0.

Source files
------------

// File: rtl/bus_slave_8085.sv
// bus_slave_8085: board-side slave on the 8085 multiplexed AD bus.
// Latches {haddress,ad_in} on ALE, classifies the machine cycle, and serves
// a 2^MEM_AW byte RAM plus one output latch and one input port, with
// WAIT_STATES cycles of READY-low per access.
// Optional statistics counters are built when BUS_SLAVE_STATS_EN is defined.
module bus_slave_8085 #(
  parameter int         MEM_AW      = 10,
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] IO_OUT_PORT = 8'h10,
  parameter logic [7:0] IO_IN_PORT  = 8'h11
) (
  input  logic        clk,
  input  logic        resetn_in,
  input  logic [7:0]  haddress,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic        ale,
  input  logic        s0,
  input  logic        s1,
  input  logic        iomn,
  input  logic        rdn,
  input  logic        wrn,
  output logic        ready,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_out,
  output logic [2:0]  cycle_type,
  output logic        bus_err
`ifdef BUS_SLAVE_STATS_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] wait_cnt
`endif
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_READ, S_WRITE, S_ERR} state_t;

  state_t      state, nxt;
  logic [15:0] addr;
  logic [2:0]  status;
  logic [2:0]  dec;
  logic [2:0]  wcnt;
  logic        is_wr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        commit;
  logic        rd_load;
  logic        unused_addr;
  logic [7:0]  mem [0:(1<<MEM_AW)-1];

  // Upper address bits only alias; they have no function beyond MEM_AW.
  assign unused_addr = ^addr;

  // Cycle class from the live status pins, used in the ALE cycle.
  always_comb begin
    case ({iomn, s1, s0})
      3'b011:  dec = 3'b001;
      3'b010:  dec = 3'b010;
      3'b001:  dec = 3'b011;
      3'b110:  dec = 3'b100;
      3'b101:  dec = 3'b101;
      3'b111:  dec = 3'b110;
      default: dec = 3'b000;
    endcase
  end

  // A write commits on the first WRITE cycle with wrn high, unless ALE aborts it.
  assign commit  = (state == S_WRITE) && wrn && !ale && resetn_in;
  assign rd_load = (nxt == S_READ) && (state != S_READ);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn_in) state <= S_IDLE;
    else            state <= nxt;
  end

  // Next state; ALE takes priority from any state and aborts the access.
  always_comb begin
    nxt = state;
    if (ale) begin
      nxt = (dec == 3'b000) ? S_IDLE : S_ADDR;
    end else begin
      case (state)
        S_ADDR: begin
          if (!rdn && !wrn)  nxt = S_ERR;
          else if (!rdn)     nxt = (WS == 3'd0) ? S_READ  : S_WAIT;
          else if (!wrn)     nxt = (WS == 3'd0) ? S_WRITE : S_WAIT;
        end
        S_WAIT:  if (wcnt <= 3'd1) nxt = is_wr ? S_WRITE : S_READ;
        S_READ:  if (rdn)          nxt = S_IDLE;
        S_WRITE: if (wrn)          nxt = S_IDLE;
        S_ERR:   if (rdn && wrn)   nxt = S_IDLE;
        default: nxt = state;
      endcase
    end
  end

  // Moore outputs; read data is only presented while in READ.
  always_comb begin
    ready  = (state != S_WAIT);
    ad_oe  = (state == S_READ);
    ad_out = (state == S_READ) ? rdata : 8'h00;
  end

  // Address/status latch, wait counter, write capture, I/O latch and error flag.
  always_ff @(posedge clk) begin
    if (!resetn_in) begin
      addr       <= 16'h0000;
      status     <= 3'b000;
      cycle_type <= 3'b000;
      wcnt       <= 3'd0;
      is_wr      <= 1'b0;
      wdata      <= 8'h00;
      io_out     <= 8'h00;
      bus_err    <= 1'b0;
    end else begin
      if (ale) begin
        addr       <= {haddress, ad_in};
        status     <= {iomn, s1, s0};
        cycle_type <= dec;
      end
      if (state == S_ADDR) begin
        wcnt  <= WS;
        is_wr <= rdn & ~wrn;
      end else if (state == S_WAIT) begin
        wcnt <= wcnt - 3'd1;
      end
      if (!wrn && (state == S_ADDR || state == S_WAIT || state == S_WRITE))
        wdata <= ad_in;
      if (commit && status[2] && addr[7:0] == IO_OUT_PORT)
        io_out <= wdata;
      if (!ale && state == S_ADDR && !rdn && !wrn)
        bus_err <= 1'b1;
    end
  end

  // Byte RAM (not reset) and read-data capture on READ entry.
  always_ff @(posedge clk) begin
    if (commit && !status[2])
      mem[addr[MEM_AW-1:0]] <= wdata;
    if (rd_load) begin
      if (status == 3'b111)      rdata <= 8'hFF;
      else if (status[2])        rdata <= (addr[7:0] == IO_IN_PORT) ? io_in : 8'hFF;
      else                       rdata <= mem[addr[MEM_AW-1:0]];
    end
  end

`ifdef BUS_SLAVE_STATS_EN
  // Completed opcode fetches and READY-low cycles, both free-running and wrapping.
  always_ff @(posedge clk) begin
    if (!resetn_in) begin
      fetch_cnt <= 16'h0000;
      wait_cnt  <= 16'h0000;
    end else begin
      if (state == S_READ && rdn && !ale && cycle_type == 3'b001)
        fetch_cnt <= fetch_cnt + 16'h0001;
      if (!ready)
        wait_cnt <= wait_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_bus_slave_8085.sv
// Directed bench for bus_slave_8085: u0 runs with one wait state, u1 with
// none; both see the same bus traffic and each keeps its own RAM.
module tb_bus_slave_8085;
  logic       clk = 1'b0;
  logic       resetn_in;
  logic [7:0] haddress, ad_in, io_in;
  logic       ale, s0, s1, iomn, rdn, wrn;

  logic [7:0] ad_out0, io_out0, ad_out1, io_out1;
  logic       ad_oe0, ready0, bus_err0, ad_oe1, ready1, bus_err1;
  logic [2:0] cycle_type0, cycle_type1;
`ifdef BUS_SLAVE_STATS_EN
  logic [15:0] fetch_cnt0, wait_cnt0, fetch_cnt1, wait_cnt1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_slave_8085 #(.MEM_AW(10), .WAIT_STATES(1)) u0 (
    .clk(clk), .resetn_in(resetn_in), .haddress(haddress), .ad_in(ad_in),
    .ad_out(ad_out0), .ad_oe(ad_oe0), .ale(ale), .s0(s0), .s1(s1), .iomn(iomn),
    .rdn(rdn), .wrn(wrn), .ready(ready0), .io_in(io_in), .io_out(io_out0),
    .cycle_type(cycle_type0), .bus_err(bus_err0)
`ifdef BUS_SLAVE_STATS_EN
    , .fetch_cnt(fetch_cnt0), .wait_cnt(wait_cnt0)
`endif
  );

  bus_slave_8085 #(.MEM_AW(10), .WAIT_STATES(0)) u1 (
    .clk(clk), .resetn_in(resetn_in), .haddress(haddress), .ad_in(ad_in),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .ale(ale), .s0(s0), .s1(s1), .iomn(iomn),
    .rdn(rdn), .wrn(wrn), .ready(ready1), .io_in(io_in), .io_out(io_out1),
    .cycle_type(cycle_type1), .bus_err(bus_err1)
`ifdef BUS_SLAVE_STATS_EN
    , .fetch_cnt(fetch_cnt1), .wait_cnt(wait_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ale_cyc(input logic [15:0] a, input logic [2:0] st);
    ale = 1'b1; haddress = a[15:8]; ad_in = a[7:0]; {iomn, s1, s0} = st;
    tick;
    ale = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [2:0] st, input logic [7:0] d);
    ale_cyc(a, st);
    ad_in = d; wrn = 1'b0;
    tick; tick;
    wrn = 1'b1;
    tick;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [2:0] st,
                         output logic [7:0] d, output logic oe, output logic [2:0] ct);
    ale_cyc(a, st);
    rdn = 1'b0;
    tick; tick;
    d = ad_out0; oe = ad_oe0; ct = cycle_type0;
    rdn = 1'b1;
    tick;
  endtask

  initial begin
    logic [7:0] d;
    logic       oe;
    logic [2:0] ct;

    resetn_in = 1'b0; ale = 1'b0; rdn = 1'b1; wrn = 1'b1;
    {iomn, s1, s0} = 3'b000; haddress = 8'h00; ad_in = 8'h00; io_in = 8'h00;

    // Reset state
    tick; tick;
    chk("rst_ad_oe", 16'(ad_oe0), 16'h0);
    chk("rst_ready", 16'(ready0), 16'h1);
    chk("rst_io_out", 16'(io_out0), 16'h00);
    chk("rst_cycle_type", 16'(cycle_type0), 16'h0);
    chk("rst_bus_err", 16'(bus_err0), 16'h0);
    chk("rst_ad_out", 16'(ad_out0), 16'h00);
    resetn_in = 1'b1;
    tick;

    // Memory write 0x0123 <- 5A with one wait state
    ale_cyc(16'h0123, 3'b001);
    chk("wr_cycle_type", 16'(cycle_type0), 16'h3);
    ad_in = 8'h5A; wrn = 1'b0;
    tick;
    chk("wr_ready_low", 16'(ready0), 16'h0);
    tick;
    chk("wr_ready_back", 16'(ready0), 16'h1);
    wrn = 1'b1;
    tick;
    chk("wr_ready_idle", 16'(ready0), 16'h1);

    // Memory read 0x0123 cycle by cycle
    ale_cyc(16'h0123, 3'b010);
    chk("rd_cycle_type", 16'(cycle_type0), 16'h2);
    rdn = 1'b0;
    tick;
    chk("rd_wait_ready", 16'(ready0), 16'h0);
    chk("rd_wait_oe", 16'(ad_oe0), 16'h0);
    tick;
    chk("rd_oe", 16'(ad_oe0), 16'h1);
    chk("rd_data", 16'(ad_out0), 16'h5A);
    tick;
    chk("rd_data_hold", 16'(ad_out0), 16'h5A);
    rdn = 1'b1;
    tick;
    chk("rd_oe_drop", 16'(ad_oe0), 16'h0);

    // Aliasing: 0x0400 and 0x0000 share RAM[0]
    do_write(16'h0400, 3'b001, 8'hC3);
    do_read(16'h0000, 3'b011, d, oe, ct);
    chk("alias_data", 16'(d), 16'hC3);
    chk("alias_ctype", 16'(ct), 16'h1);
    do_read(16'hFFFF, 3'b010, d, oe, ct);
    chk("wrap_top_empty_ok", 16'(oe), 16'h1);

    // I/O ports
    do_write(16'h1010, 3'b101, 8'hA5);
    chk("io_out", 16'(io_out0), 16'hA5);
    do_write(16'h1212, 3'b101, 8'h77);
    chk("io_out_other_port", 16'(io_out0), 16'hA5);
    io_in = 8'h3C;
    do_read(16'h1111, 3'b110, d, oe, ct);
    chk("io_in_port", 16'(d), 16'h3C);
    chk("io_in_ctype", 16'(ct), 16'h4);
    do_read(16'h1212, 3'b110, d, oe, ct);
    chk("io_in_other", 16'(d), 16'hFF);
    do_read(16'h1111, 3'b111, d, oe, ct);
    chk("inta_data", 16'(d), 16'hFF);
    chk("inta_ctype", 16'(ct), 16'h6);

    // Both strobes low -> ERR, no drive, no commit, sticky flag
    ale_cyc(16'h0123, 3'b001);
    ad_in = 8'hEE; rdn = 1'b0; wrn = 1'b0;
    tick;
    chk("err_flag", 16'(bus_err0), 16'h1);
    chk("err_oe", 16'(ad_oe0), 16'h0);
    tick;
    chk("err_oe_hold", 16'(ad_oe0), 16'h0);
    rdn = 1'b1; wrn = 1'b1;
    tick;
    chk("err_sticky", 16'(bus_err0), 16'h1);
    do_read(16'h0123, 3'b010, d, oe, ct);
    chk("err_ram_kept", 16'(d), 16'h5A);

    // ALE mid-READ aborts and latches the new address
    do_write(16'h0200, 3'b001, 8'h77);
    ale_cyc(16'h0123, 3'b010);
    rdn = 1'b0;
    tick; tick;
    chk("abort_pre_oe", 16'(ad_oe0), 16'h1);
    ale_cyc(16'h0200, 3'b010);
    chk("abort_oe", 16'(ad_oe0), 16'h0);
    tick; tick;
    chk("abort_new_data", 16'(ad_out0), 16'h77);
    rdn = 1'b1;
    tick;

    // ALE (halt) on the commit edge of a write suppresses the commit
    do_write(16'h0300, 3'b001, 8'h11);
    ale_cyc(16'h0300, 3'b001);
    ad_in = 8'h99; wrn = 1'b0;
    tick; tick;
    wrn = 1'b1;
    ale_cyc(16'h0000, 3'b000);
    chk("halt_ctype", 16'(cycle_type0), 16'h0);
    do_read(16'h0300, 3'b010, d, oe, ct);
    chk("abort_no_commit", 16'(d), 16'h11);

    // Zero wait states: three opcode fetches on u1
    resetn_in = 1'b0;
    tick; tick;
    chk("rst2_bus_err", 16'(bus_err0), 16'h0);
    resetn_in = 1'b1;
    tick;
    ale_cyc(16'h0123, 3'b011);
    rdn = 1'b0;
    tick;
    chk("f1_ready", 16'(ready1), 16'h1);
    chk("f1_data", 16'(ad_out1), 16'h5A);
    rdn = 1'b1;
    tick;
    ale_cyc(16'h0000, 3'b011);
    rdn = 1'b0;
    tick;
    chk("f2_ready", 16'(ready1), 16'h1);
    chk("f2_data", 16'(ad_out1), 16'hC3);
    rdn = 1'b1;
    tick;
    ale_cyc(16'h0200, 3'b011);
    rdn = 1'b0;
    tick;
    chk("f3_ready", 16'(ready1), 16'h1);
    chk("f3_data", 16'(ad_out1), 16'h77);
    rdn = 1'b1;
    tick;
    chk("f3_oe_drop", 16'(ad_oe1), 16'h0);
`ifdef BUS_SLAVE_STATS_EN
    chk("fetch_cnt", fetch_cnt1, 16'd3);
    chk("wait_cnt", wait_cnt1, 16'd0);
    chk("wait_cnt_ws1", wait_cnt0, 16'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
